// File: rtl/cnt_run_arbiter.sv
// Round-robin arbiter/sequencer sharing one tick-counter engine; grant 1 cycle after req, watchdog per run.
// `define ARB_STATS_EN to build the saturating completed-run counter on o_run_cnt.
module cnt_run_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WD_CYCLES  = 200000000,
  parameter int GAP_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic [N_REQ-1:0] o_done,
  output logic             o_err,
  output logic [2:0]       o_active_id,
  output logic             o_eng_start,
  input  logic             i_eng_busy,
  input  logic             i_eng_finish,
  input  logic [3:0]       i_eng_cnt,
  output logic [15:0]      o_run_cnt
);

  localparam int WD_W  = $clog2(WD_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic [N_REQ-1:0]   r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic [2:0]         r_active_id, w_id_nxt;
  logic               r_eng_start, w_start_nxt;
  logic [2:0]         r_ptr, w_ptr_nxt;
  logic [WD_W-1:0]    r_wd, w_wd_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;

  logic [2:0]         w_pick_lo, w_pick_hi, w_pick, w_ptr_adv;
  logic               w_hi_vld;
  logic [N_REQ-1:0]   w_pick_oh;
  logic               w_run_end;

  // Lowest set bit at or above ptr wins; otherwise lowest set bit overall (wrap).
  always_comb begin
    w_pick_lo = '0;
    w_pick_hi = '0;
    w_hi_vld  = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        w_pick_lo = 3'(j);
        if (j >= int'(r_ptr)) begin
          w_pick_hi = 3'(j);
          w_hi_vld  = 1'b1;
        end
      end
    end
  end

  assign w_pick    = w_hi_vld ? w_pick_hi : w_pick_lo;
  assign w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_ptr_adv = (int'(r_active_id) == N_REQ - 1) ? 3'd0 : r_active_id + 3'd1;
  assign w_run_end = !i_eng_busy && (i_eng_finish || i_eng_cnt == 4'hF);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_id_nxt    = r_active_id;
    w_start_nxt = r_eng_start;
    w_ptr_nxt   = r_ptr;
    w_wd_nxt    = r_wd;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_state_nxt = S_START;
          w_grant_nxt = w_pick_oh;
          w_id_nxt    = w_pick;
          w_start_nxt = 1'b1;
          w_wd_nxt    = '0;
        end
      end
      S_START, S_RUN: begin
        // Finish is only trusted after busy was seen; in START it is stale.
        if (r_state == S_RUN && w_run_end) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_adv;
        end else if (r_wd == WD_LAST) begin
          w_state_nxt = S_GAP;
          w_err_nxt   = 1'b1;
          w_grant_nxt = '0;
          w_start_nxt = 1'b0;
          w_ptr_nxt   = w_ptr_adv;
          w_gap_nxt   = '0;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
          if (r_state == S_START && i_eng_busy) begin
            w_start_nxt = 1'b0;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = '0;
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
        else                   w_gap_nxt   = r_gap + GAP_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_active_id <= '0;
      r_eng_start <= 1'b0;
      r_ptr       <= '0;
      r_wd        <= '0;
      r_gap       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_active_id <= w_id_nxt;
      r_eng_start <= w_start_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wd        <= w_wd_nxt;
      r_gap       <= w_gap_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_run_cnt;
  logic        w_run_inc;

  // Timeouts leave RUN/START via GAP, so only genuine completions count.
  assign w_run_inc = (r_state == S_RUN) && w_run_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run_cnt <= '0;
    else if (w_run_inc && r_run_cnt != 16'hFFFF) r_run_cnt <= r_run_cnt + 16'd1;
  end

  assign o_run_cnt = r_run_cnt;
`else
  assign o_run_cnt = 16'd0;
`endif

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_active_id = r_active_id;
  assign o_eng_start = r_eng_start;

endmodule
